// File: rtl/sar_dll_ctrl.sv
// -----------------------------------------------------------------------------
// sar_dll_ctrl
//
// Successive-approximation lock controller for the FMDLL delay line. A binary
// search on the delay code is driven by the phase-detector decision COMP. Each
// decision window is SETTLE cycles long and starts with a one-cycle PD clear.
// The code MSBs are decoded into a registered one-hot coarse select. T is
// updated on the same edge as Q, so T and Q always agree.
//
// Optional feature, macro SAR_TRACK_EN:
//   When defined, the DONE state keeps tracking. Each window steps Q by +/-1
//   with saturation. A run of TRACK_LIMIT same-direction steps drops locked.
//   A full search then restarts on the following edge.
//   When undefined, DONE holds the code and ignores COMP.
//
// Ports:
//   CLK_exit  in   controller clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   search request, level sampled each edge (ignored while busy)
//   COMP      in   PD decision: 1 = delay too short (keep bit / step up)
//   Q         out  delay code [WIDTH]
//   T         out  one-hot of Q[WIDTH-1 -: COARSE_BITS], registered
//   Tb        out  bitwise complement of T
//   Reset_PD  out  one-cycle PD clear at the start of each decision window
//   busy      out  search in progress
//   locked    out  search complete, code valid
// -----------------------------------------------------------------------------
module sar_dll_ctrl #(
    parameter int WIDTH       = 10,
    parameter int COARSE_BITS = 4,
    parameter int SETTLE      = 4,
    parameter int TRACK_LIMIT = 8
) (
    input  logic                      CLK_exit,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      COMP,
    output logic [WIDTH-1:0]          Q,
    output logic [2**COARSE_BITS-1:0] T,
    output logic [2**COARSE_BITS-1:0] Tb,
    output logic                      Reset_PD,
    output logic                      busy,
    output logic                      locked
);

    localparam int NT    = 2**COARSE_BITS;
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(SETTLE);

    // Elaboration-time parameter sanity check.
    if (WIDTH < 2 || COARSE_BITS < 1 || COARSE_BITS > WIDTH ||
        SETTLE < 2 || TRACK_LIMIT < 1) begin : g_bad_params
        $error("sar_dll_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_q;
    logic [NT-1:0]      r_t;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rpd;
    logic               r_busy;
    logic               r_locked;

    logic [WIDTH-1:0]   w_q_next;
    logic [NT-1:0]      w_t_next;
    logic [IDX_W-1:0]   w_idx_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_rpd_next;
    logic               w_busy_next;
    logic               w_locked_next;

    logic               w_sample;
    logic               w_go;

`ifdef SAR_TRACK_EN
    localparam int RUN_W = $clog2(TRACK_LIMIT + 1);

    logic               r_dir;
    logic [RUN_W-1:0]   r_run;
    logic               r_restart;
    logic               w_dir_next;
    logic [RUN_W-1:0]   w_run_next;
    logic [RUN_W-1:0]   w_run_step;
    logic               w_restart_next;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // A run-limit hit in DONE restarts the search exactly like a start request.
    assign w_go = (start | r_restart) && (r_state != S_SEARCH);
`else
    assign w_go = start && (r_state != S_SEARCH);
`endif

    // The sample edge is the last cycle of a window.
    assign w_sample = (r_cnt == CNT_W'(SETTLE - 1));

    // ---------------- state register ----------------
    always_ff @(posedge CLK_exit) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_go) w_state_next = S_SEARCH;
            S_SEARCH: if (w_sample && (r_idx == '0)) w_state_next = S_DONE;
            S_DONE:   if (w_go) w_state_next = S_SEARCH;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath / output next values ----------------
    always_comb begin
        w_q_next      = r_q;
        w_idx_next    = r_idx;
        w_cnt_next    = r_cnt;
        w_rpd_next    = 1'b0;
        w_busy_next   = r_busy;
        w_locked_next = r_locked;
`ifdef SAR_TRACK_EN
        w_dir_next     = r_dir;
        w_run_next     = r_run;
        w_run_step     = '0;
        w_restart_next = 1'b0;
`endif
        if (w_go) begin
            w_q_next      = {1'b1, {(WIDTH-1){1'b0}}};
            w_idx_next    = IDX_W'(WIDTH - 1);
            w_cnt_next    = '0;
            w_rpd_next    = 1'b1;
            w_busy_next   = 1'b1;
            w_locked_next = 1'b0;
`ifdef SAR_TRACK_EN
            w_run_next    = '0;
`endif
        end else begin
            case (r_state)
                S_SEARCH: begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (w_sample) begin
                        // Trial bit survives only if the delay is still too short.
                        w_q_next[r_idx] = COMP;
                        w_cnt_next      = '0;
                        if (r_idx != '0) begin
                            w_q_next[r_idx - 1'b1] = 1'b1;
                            w_idx_next             = r_idx - 1'b1;
                            w_rpd_next             = 1'b1;
                        end else begin
                            w_busy_next   = 1'b0;
                            w_locked_next = 1'b1;
`ifdef SAR_TRACK_EN
                            // First tracking window opens immediately.
                            w_rpd_next    = 1'b1;
`endif
                        end
                    end
                end
`ifdef SAR_TRACK_EN
                S_DONE: begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (w_sample) begin
                        w_cnt_next = '0;
                        w_rpd_next = 1'b1;
                        w_q_next   = COMP ? sat_inc(r_q) : sat_dec(r_q);
                        // Saturated steps still extend the run, so a code
                        // pinned at a rail eventually forces a re-search.
                        w_run_step = ((r_run != '0) && (r_dir == COMP)) ?
                                     r_run + 1'b1 : RUN_W'(1);
                        w_dir_next = COMP;
                        if (w_run_step == RUN_W'(TRACK_LIMIT)) begin
                            w_locked_next  = 1'b0;
                            w_restart_next = 1'b1;
                            w_run_next     = '0;
                        end else begin
                            w_run_next = w_run_step;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
        w_t_next = NT'(1) << w_q_next[WIDTH-1 -: COARSE_BITS];
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge CLK_exit) begin
        if (rst) begin
            r_q      <= '0;
            r_t      <= NT'(1);
            r_idx    <= '0;
            r_cnt    <= '0;
            r_rpd    <= 1'b0;
            r_busy   <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_q      <= w_q_next;
            r_t      <= w_t_next;
            r_idx    <= w_idx_next;
            r_cnt    <= w_cnt_next;
            r_rpd    <= w_rpd_next;
            r_busy   <= w_busy_next;
            r_locked <= w_locked_next;
        end
    end

`ifdef SAR_TRACK_EN
    always_ff @(posedge CLK_exit) begin
        if (rst) begin
            r_dir     <= 1'b0;
            r_run     <= '0;
            r_restart <= 1'b0;
        end else begin
            r_dir     <= w_dir_next;
            r_run     <= w_run_next;
            r_restart <= w_restart_next;
        end
    end
`endif

    assign Q        = r_q;
    assign T        = r_t;
    assign Tb       = ~r_t;
    assign Reset_PD = r_rpd;
    assign busy     = r_busy;
    assign locked   = r_locked;

endmodule

// File: tb/tb_sar_dll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_dll_ctrl
//
// Directed and randomised bench for sar_dll_ctrl with default parameters. The
// phase detector is modelled as COMP = (Q <= target). Expected per-edge
// behaviour is computed from the search rules. After k decisions, the code
// holds the top k bits of the target plus the next trial bit.
// -----------------------------------------------------------------------------
module tb_sar_dll_ctrl;

    localparam int W  = 10;
    localparam int CB = 4;
    localparam int ST = 4;
    localparam int NT = 16;
    localparam int LOCK_E = W * ST;

    logic          CLK_exit;
    logic          rst;
    logic          start;
    logic          COMP;
    logic [W-1:0]  Q;
    logic [NT-1:0] T;
    logic [NT-1:0] Tb;
    logic          Reset_PD;
    logic          busy;
    logic          locked;

    int target;
    bit comp_force;
    bit comp_val;
    int checks   = 0;
    int failures = 0;

    assign COMP = comp_force ? comp_val : (int'(Q) <= target);

    sar_dll_ctrl dut (
        .CLK_exit (CLK_exit),
        .rst      (rst),
        .start    (start),
        .COMP     (COMP),
        .Q        (Q),
        .T        (T),
        .Tb       (Tb),
        .Reset_PD (Reset_PD),
        .busy     (busy),
        .locked   (locked)
    );

    initial CLK_exit = 1'b0;
    always #5 CLK_exit = ~CLK_exit;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_exit);
        #1;
    endtask

    // Code after edge e of a search for tgt.
    function automatic int exp_q(input int tgt, input int e);
        int k;
        k = e / ST;
        if (k >= W) return tgt;
        return (tgt & ~((1 << (W - k)) - 1)) | (1 << (W - 1 - k));
    endfunction

    function automatic logic [31:0] exp_t(input int q);
        return 32'(1) << (q >> (W - CB));
    endfunction

    function automatic logic [31:0] exp_tb(input int q);
        logic [15:0] t;
        t = 16'(exp_t(q));
        return {16'h0, ~t};
    endfunction

    function automatic bit exp_rpd(input int e);
`ifdef SAR_TRACK_EN
        return (e % ST == 0);
`else
        return (e % ST == 0) && (e < LOCK_E);
`endif
    endfunction

    task automatic chk_edge(input string tag, input int tgt, input int e);
        int q;
        q = exp_q(tgt, e);
        chk($sformatf("%s.e%0d.Q", tag, e),  32'(Q),  32'(q));
        chk($sformatf("%s.e%0d.T", tag, e),  32'(T),  exp_t(q));
        chk($sformatf("%s.e%0d.Tb", tag, e), 32'(Tb), exp_tb(q));
        chk($sformatf("%s.e%0d.rpd", tag, e), 32'(Reset_PD), 32'(exp_rpd(e)));
        chk($sformatf("%s.e%0d.busy", tag, e), 32'(busy), 32'(e < LOCK_E));
        chk($sformatf("%s.e%0d.locked", tag, e), 32'(locked), 32'(e >= LOCK_E));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".Q"},      32'(Q),        32'h0);
        chk({tag, ".T"},      32'(T),        32'h1);
        chk({tag, ".Tb"},     32'(Tb),       32'hFFFE);
        chk({tag, ".rpd"},    32'(Reset_PD), 32'h0);
        chk({tag, ".busy"},   32'(busy),     32'h0);
        chk({tag, ".locked"}, 32'(locked),   32'h0);
    endtask

    // Full search from IDLE/DONE; optional start re-pulses at edges 5 and 20,
    // optional reset at abort_e (0 = none).
    task automatic do_search(input string tag, input int tgt, input bit repulse,
                             input int abort_e);
        target = tgt;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk_edge(tag, tgt, 0);
        for (int e = 1; e <= LOCK_E; e++) begin
            start = repulse && (e == 5 || e == 20);
            if (e == abort_e) rst = 1'b1;
            tick();
            start = 1'b0;
            if (e == abort_e) begin
                rst = 1'b0;
                chk_reset($sformatf("%s.abort", tag));
                return;
            end
            chk_edge(tag, tgt, e);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        comp_force = 1'b0;
        comp_val   = 1'b0;
        target     = 0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();
        chk_reset("idle");

        do_search("t677", 677, 1'b0, 0);
        chk("t677.final.T",  32'(T),  32'h0400);
        chk("t677.final.Tb", 32'(Tb), 32'hFBFF);

        do_search("t0", 0, 1'b0, 0);
        chk("t0.final.T", 32'(T), 32'h0001);

        do_search("t1023", 1023, 1'b0, 0);
        chk("t1023.final.T", 32'(T), 32'h8000);

        do_search("abort", int'($urandom_range(0, 1023)), 1'b0, 17);
        do_search("relock", 677, 1'b0, 0);

        do_search("repulse", int'($urandom_range(0, 1023)), 1'b1, 0);

        for (int i = 0; i < 4; i++)
            do_search($sformatf("rand%0d", i), int'($urandom_range(0, 1023)), 1'b0, 0);

`ifndef SAR_TRACK_EN
        // DONE holds the code regardless of COMP.
        do_search("hold", 677, 1'b0, 0);
        comp_force = 1'b1;
        for (int c = 0; c < 12; c++) begin
            comp_val = c[0];
            tick();
            chk($sformatf("hold.c%0d.Q", c),      32'(Q),        32'd677);
            chk($sformatf("hold.c%0d.locked", c), 32'(locked),   32'h1);
            chk($sformatf("hold.c%0d.rpd", c),    32'(Reset_PD), 32'h0);
            chk($sformatf("hold.c%0d.busy", c),   32'(busy),     32'h0);
        end
        comp_force = 1'b0;
`else
        // Tracking toward a moved target, then dithering around it.
        begin
            int mq;
            do_search("trk", 677, 1'b0, 0);
            target = 680;
            mq = 677;
            for (int s = 1; s <= 8; s++) begin
                repeat (ST) tick();
                mq = (mq <= 680) ? ((mq < 1023) ? mq + 1 : mq) : ((mq > 0) ? mq - 1 : mq);
                chk($sformatf("trk.s%0d.Q", s),      32'(Q),        32'(mq));
                chk($sformatf("trk.s%0d.locked", s), 32'(locked),   32'h1);
                chk($sformatf("trk.s%0d.rpd", s),    32'(Reset_PD), 32'h1);
            end
        end
        // Monotonic run forces a re-search.
        do_search("run", 677, 1'b0, 0);
        comp_force = 1'b1;
        comp_val   = 1'b1;
        for (int s = 1; s <= 8; s++) begin
            repeat (ST) tick();
            chk($sformatf("run.s%0d.Q", s),      32'(Q),      32'(677 + s));
            chk($sformatf("run.s%0d.locked", s), 32'(locked), 32'(s < 8));
        end
        tick();
        chk("run.restart.busy",   32'(busy),   32'h1);
        chk("run.restart.Q",      32'(Q),      32'h200);
        chk("run.restart.locked", 32'(locked), 32'h0);
        comp_force = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("run.reset");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
